// File: rtl/trace_dump_unit.sv
// trace_dump_unit: retire-trace recorder and end-of-run memory dump engine.
//
// Records retired {pc, inst} pairs in a circular buffer while the program
// runs. It detects the end of the program when a retiring pc word index is
// >= max_pc. After that it drains the buffer oldest-first and then streams
// RAM words 0..RAMDEPTH-1. Everything leaves through one valid/ready port.
//
// Optional build macro: TRACE_CLASS_COUNT_EN
//   Adds six saturating instruction-class counters. Their values are
//   emitted as kind-3 beats after the last memory word.
//
// Output handshake: a beat transfers on a rising edge where
// out_valid && out_ready. While out_valid=1 and out_ready=0, out_data and
// out_kind hold. out_valid only falls after a transfer.
//
// The fsm_state output mirrors the internal state for observation.
// RUN=0, DRAIN=1, DUMP=2, COUNT=3, DONE=4.
module trace_dump_unit #(
  parameter int XLEN        = 32,
  parameter int TRACE_DEPTH = 16,
  parameter int RAMDEPTH    = 256,
  parameter int CNT_W       = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [XLEN-1:0]             max_pc,
  input  logic                        ret_valid,
  input  logic [XLEN-1:0]             ret_pc,
  input  logic [XLEN-1:0]             ret_inst,
  output logic                        mem_ren,
  output logic [$clog2(RAMDEPTH)-1:0] mem_addr,
  input  logic [XLEN-1:0]             mem_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [XLEN-1:0]             out_data,
  output logic [1:0]                  out_kind,
  output logic                        halted,
  output logic                        overflow,
  output logic                        done,
  output logic [2:0]                  fsm_state
);

  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int AW = $clog2(RAMDEPTH);
  localparam logic [PW:0] FULL      = (PW+1)'(TRACE_DEPTH);
  localparam logic [PW:0] ONE_ENTRY = (PW+1)'(1);
  localparam logic [AW:0] RD_END    = (AW+1)'(RAMDEPTH);

  localparam logic [1:0] K_PC   = 2'd0;
  localparam logic [1:0] K_INST = 2'd1;
  localparam logic [1:0] K_MEM  = 2'd2;
`ifdef TRACE_CLASS_COUNT_EN
  localparam logic [1:0] K_CNT  = 2'd3;
`endif

  // Reject parameter combinations the pointer arithmetic cannot handle.
  if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
    $error("trace_dump_unit: TRACE_DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_DRAIN = 3'd1,
    S_DUMP  = 3'd2,
    S_CNT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc_mem   [TRACE_DEPTH];
  logic [XLEN-1:0] inst_mem [TRACE_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   rd_next;
  logic [PW:0]     count;
  logic [AW:0]     rd_cnt;     // next RAM address to read; RD_END once all are issued
  logic            inflight;   // RAM data for the last read arrives this cycle

  logic [XLEN-1:0] ret_word;
  logic            in_range;
  logic            push;
  logic            halt_hit;
  logic            accept;

  assign fsm_state = state;
  assign ret_word  = ret_pc >> 2;
  assign in_range  = ret_word < max_pc;
  assign push      = (state == S_RUN) && ret_valid && in_range;
  assign halt_hit  = (state == S_RUN) && ret_valid && !in_range;
  assign accept    = out_valid && out_ready;
  assign rd_next   = rd_ptr + 1'b1;

  // The read strobe is decoded from registered state and the sink's ready.
  // This lets the next read issue in the cycle its predecessor is accepted,
  // which gives one word every two cycles. A read never issues while a
  // beat is stalled.
  assign mem_ren  = (state == S_DUMP) && !inflight && (rd_cnt < RD_END) &&
                    (!out_valid || out_ready);
  assign mem_addr = rd_cnt[AW-1:0];

`ifdef TRACE_CLASS_COUNT_EN
  logic [CNT_W-1:0] class_cnt [6];
  logic [2:0]       cls;
  logic [2:0]       cnt_idx;

  // Map the opcode of the retiring instruction to its counter slot.
  always_comb begin
    cls = 3'd5;
    case (ret_inst[6:0])
      7'b0110011: cls = 3'd0;
      7'b0010011: cls = 3'd1;
      7'b0000011: cls = 3'd2;
      7'b0100011: cls = 3'd3;
      7'b1100011: cls = 3'd4;
      default:    cls = 3'd5;
    endcase
  end

  // Count every recorded retire by class. Counters saturate at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) class_cnt[i] <= '0;
    end else if (push && (class_cnt[cls] != {CNT_W{1'b1}})) begin
      class_cnt[cls] <= class_cnt[cls] + 1'b1;
    end
  end
`endif

  // Trace storage is written on every recorded retire and needs no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr]   <= ret_pc;
      inst_mem[wr_ptr] <= ret_inst;
    end
  end

  // Main control: buffer pointers, phase sequencing and the output register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_cnt    <= '0;
      inflight  <= 1'b0;
      halted    <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_kind  <= K_PC;
`ifdef TRACE_CLASS_COUNT_EN
      cnt_idx   <= '0;
`endif
    end else begin
      case (state)
        S_RUN: begin
          if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count == FULL) begin
              // Overwrite the oldest entry; the read side moves with it.
              rd_ptr   <= rd_ptr + 1'b1;
              overflow <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end else if (halt_hit) begin
            halted <= 1'b1;
            state  <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (!out_valid) begin
            if (count == '0) begin
              state <= S_DUMP;
            end else begin
              out_valid <= 1'b1;
              out_data  <= pc_mem[rd_ptr];
              out_kind  <= K_PC;
            end
          end else if (out_ready) begin
            if (out_kind == K_PC) begin
              out_data <= inst_mem[rd_ptr];
              out_kind <= K_INST;
            end else begin
              // The inst beat was taken, so the entry retires here.
              rd_ptr <= rd_next;
              count  <= count - 1'b1;
              if (count > ONE_ENTRY) begin
                out_data <= pc_mem[rd_next];
                out_kind <= K_PC;
              end else begin
                out_valid <= 1'b0;
              end
            end
          end
        end

        S_DUMP: begin
          if (mem_ren) begin
            rd_cnt   <= rd_cnt + 1'b1;
            inflight <= 1'b1;
          end
          if (inflight) begin
            inflight  <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= mem_rdata;
            out_kind  <= K_MEM;
          end else if (accept) begin
            if (rd_cnt == RD_END) begin
`ifdef TRACE_CLASS_COUNT_EN
              state    <= S_CNT;
              out_data <= XLEN'(class_cnt[0]);
              out_kind <= K_CNT;
              cnt_idx  <= 3'd0;
`else
              state     <= S_DONE;
              done      <= 1'b1;
              out_valid <= 1'b0;
`endif
            end else begin
              out_valid <= 1'b0;
            end
          end
        end

`ifdef TRACE_CLASS_COUNT_EN
        S_CNT: begin
          if (accept) begin
            if (cnt_idx == 3'd5) begin
              state     <= S_DONE;
              done      <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              cnt_idx  <= cnt_idx + 3'd1;
              out_data <= XLEN'(class_cnt[cnt_idx + 3'd1]);
            end
          end
        end
`endif

        S_DONE: begin
          out_valid <= 1'b0;
          done      <= 1'b1;
        end

        default: begin
          state     <= S_DONE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_dump_unit.sv
// Directed testbench for trace_dump_unit (TRACE_DEPTH=4, RAMDEPTH=8).
// Inputs change 1 ns after the rising edge. Outputs are observed on the
// falling edge. A monitor records every accepted beat as {kind, data} and
// counts handshake-rule violations. Each test compares against an expected
// queue that it builds itself.
module tb_trace_dump_unit;

  localparam int XLEN = 32;
  localparam int TD   = 4;
  localparam int RD   = 8;
  localparam int CW   = 32;
  localparam int AW   = 3;
  localparam int BW   = 34;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [XLEN-1:0] max_pc    = '0;
  logic            ret_valid = 1'b0;
  logic [XLEN-1:0] ret_pc    = '0;
  logic [XLEN-1:0] ret_inst  = '0;
  logic            mem_ren;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic [1:0]      out_kind;
  logic            halted;
  logic            overflow;
  logic            done;
  logic [2:0]      fsm_state;

  trace_dump_unit #(.XLEN(XLEN), .TRACE_DEPTH(TD), .RAMDEPTH(RD), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .max_pc(max_pc),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_kind(out_kind), .halted(halted), .overflow(overflow), .done(done),
    .fsm_state(fsm_state)
  );

  // Synchronous-read RAM model: data valid the cycle after mem_ren.
  logic [XLEN-1:0] ram [RD];
  always @(posedge clock) if (mem_ren) mem_rdata <= ram[mem_addr];

  int checks = 0;
  int passed = 0;

  // ---------------- sink ready driver ----------------
  logic rand_ready  = 1'b0;
  logic ready_level = 1'b0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [BW-1:0] got_q[$];
  logic [BW-1:0] exp_q[$];
  int stall_err = 0;
  int drop_err  = 0;
  int ren_err   = 0;
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_beat  = '0;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !out_valid) drop_err++;
        if (prev_stall && out_valid && ({out_kind, out_data} !== prev_beat)) stall_err++;
        if (mem_ren && out_valid && !out_ready) ren_err++;
        if (out_valid && out_ready) got_q.push_back({out_kind, out_data});
        prev_stall = out_valid && !out_ready;
        prev_beat  = {out_kind, out_data};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset      = 1'b1;
    ret_valid  = 1'b0;
    rand_ready = 1'b0;
    ready_level = 1'b0;
    got_q.delete();
    exp_q.delete();
    stall_err = 0;
    drop_err  = 0;
    ren_err   = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Present one retire for one cycle. Call at 1 ns after a rising edge.
  task automatic retire(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst);
    ret_valid = 1'b1;
    ret_pc    = pc;
    ret_inst  = inst;
    @(posedge clock);
    #1;
    ret_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget && done !== 1'b1; n++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic exp_trace(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst);
    exp_q.push_back({2'd0, pc});
    exp_q.push_back({2'd1, inst});
  endtask

  task automatic exp_mem();
    for (int k = 0; k < RD; k++) exp_q.push_back({2'd2, ram[k]});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid === 1'b0 && mem_ren === 1'b0 && mem_addr === 3'd0) passed++;
    else $display("FAIL reset_outputs: got valid=%b ren=%b addr=%0d want 0 0 0", out_valid, mem_ren, mem_addr);
    checks++;
    if (halted === 1'b0 && overflow === 1'b0 && done === 1'b0) passed++;
    else $display("FAIL reset_flags: got halted=%b overflow=%b done=%b want 0 0 0", halted, overflow, done);
    checks++;
    if (fsm_state === 3'd0) passed++;
    else $display("FAIL reset_state: got %0d want 0", fsm_state);
  endtask

  task automatic test_basic_halt();
    logic [XLEN-1:0] insts [4];
    insts = '{32'h0020_81b3, 32'h0010_0093, 32'h0000_a103, 32'h0020_a023};
    do_reset();
    max_pc = 3;
    ready_level = 1'b1;
    for (int i = 0; i < 4; i++) retire(XLEN'(i * 4), insts[i]);
    checks++;
    if (halted === 1'b1 && out_valid === 1'b0) passed++;
    else $display("FAIL halt_latch: got halted=%b valid=%b want 1 0", halted, out_valid);
    @(posedge clock);
    #1;
    checks++;
    if (out_valid === 1'b1 && out_kind === 2'd0 && out_data === 32'd0) passed++;
    else $display("FAIL first_beat_latency: got valid=%b kind=%0d data=%h want 1 0 0", out_valid, out_kind, out_data);
    wait_done(400);
    checks++;
    if (done === 1'b1 && overflow === 1'b0) passed++;
    else $display("FAIL basic_done: got done=%b overflow=%b want 1 0", done, overflow);
    for (int i = 0; i < 3; i++) exp_trace(XLEN'(i * 4), insts[i]);
    exp_mem();
    checks++;
    if (got_q.size() === exp_q.size()) passed++;
    else $display("FAIL basic_count: got %0d beats want %0d", got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      if (i < got_q.size() && got_q[i] === exp_q[i]) passed++;
      else $display("FAIL basic_beat%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    max_pc = 6;
    ready_level = 1'b1;
    for (int i = 0; i < 6; i++) retire(XLEN'(i * 4), 32'h1000_0000 + 32'(i));
    retire(32'd24, 32'h0000_006f);
    wait_done(400);
    checks++;
    if (overflow === 1'b1 && done === 1'b1) passed++;
    else $display("FAIL overflow_flag: got overflow=%b done=%b want 1 1", overflow, done);
    for (int i = 2; i < 6; i++) exp_trace(XLEN'(i * 4), 32'h1000_0000 + 32'(i));
    exp_mem();
    checks++;
    if (got_q.size() === exp_q.size()) passed++;
    else $display("FAIL overflow_count: got %0d beats want %0d", got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      if (i < got_q.size() && got_q[i] === exp_q[i]) passed++;
      else $display("FAIL overflow_beat%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    max_pc = 10;
    rand_ready = 1'b1;
    retire(32'd0, 32'h00a0_0513);
    retire(32'd4, 32'h00b5_05b3);
    retire(32'd8, 32'hfe05_8ee3);
    retire(32'd40, 32'h0000_0073);
    wait_done(2000);
    checks++;
    if (done === 1'b1) passed++;
    else $display("FAIL bp_done: got %b want 1", done);
    checks++;
    if (stall_err === 0 && drop_err === 0) passed++;
    else $display("FAIL bp_stable: got %0d unstable, %0d dropped want 0 0", stall_err, drop_err);
    checks++;
    if (ren_err === 0) passed++;
    else $display("FAIL bp_ren_stalled: got %0d want 0", ren_err);
    exp_trace(32'd0, 32'h00a0_0513);
    exp_trace(32'd4, 32'h00b5_05b3);
    exp_trace(32'd8, 32'hfe05_8ee3);
    exp_mem();
    checks++;
    if (got_q.size() === exp_q.size()) passed++;
    else $display("FAIL bp_count: got %0d beats want %0d", got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      if (i < got_q.size() && got_q[i] === exp_q[i]) passed++;
      else $display("FAIL bp_beat%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
    end
    rand_ready = 1'b0;
  endtask

  task automatic test_immediate_halt();
    do_reset();
    max_pc = 0;
    ready_level = 1'b1;
    retire(32'd0, 32'h0000_0013);
    wait_done(400);
    exp_mem();
    checks++;
    if (got_q.size() > 0 && got_q[0] === {2'd2, ram[0]}) passed++;
    else $display("FAIL imm_first_beat: got %h want %h", (got_q.size() > 0) ? got_q[0] : 'x, {2'd2, ram[0]});
    checks++;
    if (got_q.size() === exp_q.size() && done === 1'b1 && overflow === 1'b0) passed++;
    else $display("FAIL imm_count: got %0d beats done=%b want %0d done=1", got_q.size(), done, exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      if (i < got_q.size() && got_q[i] === exp_q[i]) passed++;
      else $display("FAIL imm_beat%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
    end
  endtask

  task automatic test_reset_mid_dump();
    logic found;
    do_reset();
    max_pc = 0;
    ready_level = 1'b1;
    retire(32'd0, 32'h0000_0013);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clock);
      if (mem_ren === 1'b1 && mem_addr === 3'd5) found = 1'b1;
    end
    checks++;
    if (found) passed++;
    else $display("FAIL mid_reach_addr5: got %b want 1", found);
    // Assert reset away from any clock edge; outputs must clear at once.
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid === 1'b0 && mem_ren === 1'b0 && mem_addr === 3'd0) passed++;
    else $display("FAIL mid_async_outputs: got valid=%b ren=%b addr=%0d want 0 0 0", out_valid, mem_ren, mem_addr);
    checks++;
    if (halted === 1'b0 && done === 1'b0 && fsm_state === 3'd0) passed++;
    else $display("FAIL mid_async_state: got halted=%b done=%b state=%0d want 0 0 0", halted, done, fsm_state);
    @(posedge clock);
    #1;
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    max_pc = 1;
    retire(32'd0, 32'h0041_0113);
    retire(32'd4, 32'h0000_0073);
    @(posedge clock);
    #1;
    checks++;
    if (done === 1'b0) passed++;
    else $display("FAIL mid_done_early: got %b want 0", done);
    wait_done(400);
    checks++;
    if (done === 1'b1) passed++;
    else $display("FAIL mid_rerun_done: got %b want 1", done);
    exp_trace(32'd0, 32'h0041_0113);
    exp_mem();
    checks++;
    if (got_q.size() === exp_q.size()) passed++;
    else $display("FAIL mid_count: got %0d beats want %0d", got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      if (i < got_q.size() && got_q[i] === exp_q[i]) passed++;
      else $display("FAIL mid_beat%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
    end
  endtask

`ifdef TRACE_CLASS_COUNT_EN
  task automatic test_class_count();
    logic [XLEN-1:0] insts [8];
    insts = '{32'h0020_81b3, 32'h0031_8233, 32'h0010_0093, 32'h0000_a103,
              32'h0020_a023, 32'h0020_8063, 32'h0031_8063, 32'h0000_10b7};
    do_reset();
    max_pc = 8;
    ready_level = 1'b1;
    for (int i = 0; i < 8; i++) retire(XLEN'(i * 4), insts[i]);
    retire(32'd32, 32'h0000_0073);
    wait_done(400);
    for (int i = 4; i < 8; i++) exp_trace(XLEN'(i * 4), insts[i]);
    exp_mem();
    exp_q.push_back({2'd3, 32'd2});
    exp_q.push_back({2'd3, 32'd1});
    exp_q.push_back({2'd3, 32'd1});
    exp_q.push_back({2'd3, 32'd1});
    exp_q.push_back({2'd3, 32'd2});
    exp_q.push_back({2'd3, 32'd1});
    checks++;
    if (got_q.size() === exp_q.size() && done === 1'b1) passed++;
    else $display("FAIL cnt_count: got %0d beats done=%b want %0d done=1", got_q.size(), done, exp_q.size());
    foreach (exp_q[i]) begin
      checks++;
      if (i < got_q.size() && got_q[i] === exp_q[i]) passed++;
      else $display("FAIL cnt_beat%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
    end
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    for (int k = 0; k < RD; k++) ram[k] = 32'hd00d_0000 + (32'(k) << 8) + 32'($urandom_range(0, 255));
    test_reset();
    test_basic_halt();
    test_overflow();
    test_backpressure();
    test_immediate_halt();
    test_reset_mid_dump();
`ifdef TRACE_CLASS_COUNT_EN
    test_class_count();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
